// File: rtl/id_pipe.sv
// id_pipe: decode stage with bypassed register file, load-use stall, branch flush and HALT latch.
module id_pipe #(
  parameter int DATA_W = 32,
  parameter int NUM_REGS = 32,
  parameter int PC_W = 32,
  parameter int STALL_CNT_W = 16,
  localparam int AW = $clog2(NUM_REGS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   if_valid,
  output logic                   if_ready,
  input  logic [31:0]            inst,
  input  logic [PC_W-1:0]        pc_in,
  input  logic [PC_W-1:0]        pc4_in,
  input  logic                   wb_we,
  input  logic [AW-1:0]          wb_addr,
  input  logic [DATA_W-1:0]      wb_data,
  input  logic                   flush,
  input  logic                   ex_ready,
  output logic                   ex_valid,
  output logic [5:0]             opcode_out,
  output logic [DATA_W-1:0]      rs_val,
  output logic [DATA_W-1:0]      rt_val,
  output logic [AW-1:0]          rd_addr,
  output logic [DATA_W-1:0]      imm,
  output logic                   reg_write,
  output logic                   branch,
  output logic                   mem_read,
  output logic                   mem_to_reg,
  output logic                   mem_write,
  output logic [PC_W-1:0]        pc_out,
  output logic [PC_W-1:0]        pc4_out,
  output logic                   halted,
  output logic [STALL_CNT_W-1:0] stall_cnt
);
  logic [DATA_W-1:0] rf_q [NUM_REGS];
  logic [5:0] op;
  logic [AW-1:0] rs_a, rt_a;
  logic r_t, i_t, ldw, stw, bz, beq, jr, hlt, use_rt, hazard, accept, bubble;
  logic [DATA_W-1:0] rs_rd, rt_rd, rs_d, rt_d, imm_d;
  logic [AW-1:0] rd_d;
  logic ex_valid_q, halted_q;
  logic [5:0] op_q;
  logic [DATA_W-1:0] rs_q, rt_q, imm_q;
  logic [AW-1:0] rd_q;
  logic [4:0] ctl_q;
  logic [PC_W-1:0] pc_q, pc4_q;
  logic [STALL_CNT_W-1:0] stall_q;
  assign op = inst[31:26];
  assign rs_a = AW'(inst[25:21]);
  assign rt_a = AW'(inst[20:16]);
  assign r_t = op <= 6'h0A && !op[0];
  assign i_t = op <= 6'h0B && op[0];
  assign ldw = op == 6'h0C;
  assign stw = op == 6'h0D;
  assign bz = op == 6'h0E;
  assign beq = op == 6'h0F;
  assign jr = op == 6'h10;
  assign hlt = op == 6'h11;
  assign use_rt = r_t || stw || beq;
  // WB write-through: a same-cycle write is visible to the read
  assign rs_rd = (wb_we && wb_addr != '0 && wb_addr == rs_a) ? wb_data : rf_q[rs_a];
  assign rt_rd = (wb_we && wb_addr != '0 && wb_addr == rt_a) ? wb_data : rf_q[rt_a];
  assign rs_d = (r_t || i_t || ldw || stw || bz || beq || jr) ? rs_rd : '0;
  assign rt_d = use_rt ? rt_rd : '0;
  assign rd_d = r_t ? AW'(inst[15:11]) : (i_t || ldw) ? rt_a : '0;
  assign imm_d = (i_t || ldw || stw || bz || beq || jr) ? {{(DATA_W-16){inst[15]}}, inst[15:0]} : '0;
  assign hazard = ex_valid_q && ctl_q[2] && rd_q != '0 && (rd_q == rs_a || (use_rt && rd_q == rt_a));
  assign if_ready = flush || (!halted_q && !hazard && (ex_ready || !ex_valid_q));
  assign accept = if_valid && if_ready && !flush;
  assign bubble = if_valid && hazard && ex_ready && !flush;
  always_ff @(posedge clk or negedge reset)
    if (!reset) for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    else if (wb_we && wb_addr != '0) rf_q[wb_addr] <= wb_data;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      ex_valid_q <= 1'b0;
      op_q <= '0;
      rs_q <= '0;
      rt_q <= '0;
      rd_q <= '0;
      imm_q <= '0;
      ctl_q <= '0;
      pc_q <= '0;
      pc4_q <= '0;
      halted_q <= 1'b0;
      stall_q <= '0;
    end else begin
      if (flush) ex_valid_q <= 1'b0;
      else if (!(ex_valid_q && !ex_ready)) begin
        ex_valid_q <= accept;
        if (accept) begin
          op_q <= op;
          rs_q <= rs_d;
          rt_q <= rt_d;
          rd_q <= rd_d;
          imm_q <= imm_d;
          ctl_q <= {r_t || i_t || ldw, bz || beq || jr, ldw, ldw, stw};
          pc_q <= pc_in;
          pc4_q <= pc4_in;
        end
      end
      if (accept && hlt) halted_q <= 1'b1;
      if (bubble && stall_q != '1) stall_q <= stall_q + STALL_CNT_W'(1);
    end
  assign ex_valid = ex_valid_q;
  assign opcode_out = op_q;
  assign rs_val = rs_q;
  assign rt_val = rt_q;
  assign rd_addr = rd_q;
  assign imm = imm_q;
  assign {reg_write, branch, mem_read, mem_to_reg, mem_write} = ctl_q;
  assign pc_out = pc_q;
  assign pc4_out = pc4_q;
  assign halted = halted_q;
  assign stall_cnt = stall_q;
endmodule

// File: tb/tb_id_pipe.sv
// tb_id_pipe: randomized scoreboard bench for id_pipe with a transaction-level reference model.
module tb_id_pipe;
  logic clk = 0, reset = 0;
  logic if_valid = 0, if_ready, wb_we = 0, flush = 0, ex_ready = 1, ex_valid;
  logic [31:0] inst = 0, pc_in = 0, pc4_in = 0, wb_data = 0;
  logic [4:0] wb_addr = 0, rd_addr;
  logic [5:0] opcode_out;
  logic [31:0] rs_val, rt_val, imm, pc_out, pc4_out;
  logic reg_write, branch, mem_read, mem_to_reg, mem_write, halted;
  logic [15:0] stall_cnt;
  always #5 clk = ~clk;
  id_pipe dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_ready(if_ready), .inst(inst),
    .pc_in(pc_in), .pc4_in(pc4_in), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid), .opcode_out(opcode_out),
    .rs_val(rs_val), .rt_val(rt_val), .rd_addr(rd_addr), .imm(imm), .reg_write(reg_write),
    .branch(branch), .mem_read(mem_read), .mem_to_reg(mem_to_reg), .mem_write(mem_write),
    .pc_out(pc_out), .pc4_out(pc4_out), .halted(halted), .stall_cnt(stall_cnt)
  );
  typedef struct packed {
    logic [5:0] op;
    logic [31:0] a, b;
    logic [4:0] rd;
    logic [31:0] imm;
    logic rw, br, mr, mtr, mw;
    logic [31:0] pc, pc4;
  } exp_t;
  exp_t q[$];
  exp_t act;
  int checks = 0, errors = 0;
  logic [31:0] regs [32];
  logic m_exv = 0, m_halt = 0;
  logic [4:0] m_ld = 0;
  int m_stall = 0;
  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask
  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] lo);
    return {op, rs, rt, lo};
  endfunction
  function automatic exp_t model_dec(input logic [31:0] in, input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc, input logic [31:0] pc4);
    exp_t e = '0;
    logic [5:0] op = in[31:26];
    logic [31:0] sx = {{16{in[15]}}, in[15:0]};
    e.op = op;
    e.pc = pc;
    e.pc4 = pc4;
    if (op <= 6'h0B && !op[0]) begin
      e.a = a; e.b = b; e.rd = in[15:11]; e.rw = 1;
    end else if (op <= 6'h0C) begin
      e.a = a; e.rd = in[20:16]; e.imm = sx; e.rw = 1; e.mr = (op == 6'h0C); e.mtr = e.mr;
    end else if (op == 6'h0D) begin
      e.a = a; e.b = b; e.imm = sx; e.mw = 1;
    end else if (op >= 6'h0E && op <= 6'h10) begin
      e.a = a; e.b = (op == 6'h0F) ? b : 32'h0; e.imm = sx; e.br = 1;
    end
    return e;
  endfunction
  task automatic step(input logic v, input logic [31:0] in, input logic we, input logic [4:0] wa,
                      input logic [31:0] wd, input logic fl, input logic er);
    logic hz, rdy, acc, use_rt;
    logic [4:0] rs, rt;
    logic [5:0] op;
    logic [31:0] av, bv;
    @(negedge clk);
    if_valid = v; inst = in; wb_we = we; wb_addr = wa; wb_data = wd; flush = fl; ex_ready = er;
    pc_in = $urandom; pc4_in = pc_in + 4;
    #1;
    op = in[31:26]; rs = in[25:21]; rt = in[20:16];
    use_rt = (op <= 6'h0B && !op[0]) || op == 6'h0D || op == 6'h0F;
    // a load still sitting in the EX register cannot feed a consumer yet
    hz = m_exv && m_ld != 0 && (m_ld == rs || (use_rt && m_ld == rt));
    rdy = fl || (!m_halt && !hz && (er || !m_exv));
    acc = v && rdy && !fl;
    chk("if_ready", if_ready, rdy);
    chk("halted", halted, m_halt);
    chk("stall_cnt", stall_cnt, m_stall);
    av = (we && wa != 0 && wa == rs) ? wd : regs[rs];
    bv = (we && wa != 0 && wa == rt) ? wd : regs[rt];
    if (acc) q.push_back(model_dec(in, av, bv, pc_in, pc4_in));
    if (v && hz && er && !fl && m_stall < 65535) m_stall++;
    if (fl) m_exv = 0;
    else if (!(m_exv && !er)) begin
      m_exv = acc;
      if (acc) m_ld = (op == 6'h0C) ? rt : 5'd0;
    end
    if (acc && op == 6'h11) m_halt = 1;
    if (we && wa != 0) regs[wa] = wd;
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 0; if_valid = 0; wb_we = 0; flush = 0; ex_ready = 1;
    #1;
    chk("rst ex_valid", ex_valid, 0);
    chk("rst fields", {opcode_out, rs_val, rt_val, rd_addr, imm, reg_write, branch, mem_read, mem_to_reg, mem_write, pc_out, pc4_out}, 0);
    chk("rst halted", halted, 0);
    chk("rst stall_cnt", stall_cnt, 0);
    q.delete();
    m_exv = 0; m_halt = 0; m_ld = 0; m_stall = 0;
    for (int i = 0; i < 32; i++) regs[i] = 0;
    @(negedge clk);
    reset = 1;
  endtask
  initial forever begin
    @(negedge clk);
    #2;
    if (reset && ex_valid && !flush) begin
      act = {opcode_out, rs_val, rt_val, rd_addr, imm, reg_write, branch, mem_read, mem_to_reg, mem_write, pc_out, pc4_out};
      if (q.size() == 0) chk("unexpected output", act, 0);
      else if (ex_ready) chk("output", act, q.pop_front());
      else chk("held output", act, q[0]);
    end else if (reset && ex_valid && flush && q.size() != 0) void'(q.pop_front());
  end
  initial begin
    logic [5:0] op;
    logic [31:0] lo;
    do_reset();
    step(0, 0, 1, 5, 32'h1234, 0, 1);
    step(1, mk(6'h00, 5, 0, {5'd3, 11'd0}), 0, 0, 0, 0, 1);
    step(1, mk(6'h01, 7, 2, 16'hFFF0), 1, 7, 32'h10, 0, 1);
    step(1, mk(6'h0C, 1, 4, 16'h0008), 0, 0, 0, 0, 1);
    step(1, mk(6'h00, 4, 2, {5'd9, 11'd0}), 0, 0, 0, 0, 1);
    step(1, mk(6'h00, 4, 2, {5'd9, 11'd0}), 0, 0, 0, 0, 1);
    chk("load-use stall_cnt", stall_cnt, 1);
    step(1, mk(6'h0F, 3, 7, 16'h0004), 0, 0, 0, 0, 1);
    step(1, mk(6'h02, 1, 2, {5'd6, 11'd0}), 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("flush ex_valid", ex_valid, 0);
    step(1, mk(6'h0D, 7, 5, 16'h0010), 0, 0, 0, 0, 1);
    step(1, mk(6'h00, 6, 5, {5'd1, 11'd0}), 0, 0, 0, 0, 0);
    step(1, mk(6'h00, 6, 5, {5'd1, 11'd0}), 1, 6, 32'hCAFE, 0, 0);
    step(1, mk(6'h00, 6, 5, {5'd1, 11'd0}), 0, 0, 0, 0, 0);
    step(1, mk(6'h00, 6, 5, {5'd1, 11'd0}), 0, 0, 0, 0, 1);
    repeat (1500) begin
      op = 6'($urandom_range(0, 19));
      if (op > 6'h10) op = 6'($urandom_range(18, 63));
      lo = $urandom;
      step($urandom_range(0, 4) != 0, mk(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), lo[15:0]),
           $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
    end
    step(1, mk(6'h11, 0, 0, 0), 0, 0, 0, 0, 1);
    repeat (4) step(1, mk(6'h00, 1, 2, {5'd3, 11'd0}), 0, 0, 0, 0, 1);
    chk("halt sticky", halted, 1);
    do_reset();
    for (int i = 0; i < 16; i++) step(1, mk(6'h0F, 5'(2 * i), 5'(2 * i + 1), 0), 0, 0, 0, 0, 1);
    repeat (4) step(0, 0, 0, 0, 0, 0, 1);
    chk("queue drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
